// File: rtl/key_event_gen_if.sv
// Signal bundle between the key event generator and its consumer.
// The slave modport is the generator's view; master is the driving/observing side.
interface key_event_gen_if #(
  parameter int unsigned COUNTWIDTH = 4
) ();
  logic                  ispressedin;
  logic                  countclear;
  logic                  presspulse;
  logic                  releasepulse;
  logic                  repeatpulse;
  logic                  longhold;
  logic [COUNTWIDTH-1:0] presscount;

  modport master (
    output ispressedin,
    output countclear,
    input  presspulse,
    input  releasepulse,
    input  repeatpulse,
    input  longhold,
    input  presscount
  );

  modport slave (
    input  ispressedin,
    input  countclear,
    output presspulse,
    output releasepulse,
    output repeatpulse,
    output longhold,
    output presscount
  );
endinterface

// File: rtl/key_event_gen.sv
// Converts a debounced, asynchronous pressed level into registered press, release and
// auto-repeat pulses, a long-hold flag and a wrapping press counter.
module key_event_gen #(
  parameter int unsigned HOLDCYCLES   = 8,
  parameter int unsigned REPEATCYCLES = 4,
  parameter int unsigned TIMERWIDTH   = 24,
  parameter int unsigned COUNTWIDTH   = 4
) (
  input logic           clock,
  input logic           reset,
  key_event_gen_if.slave bus
);

  localparam logic [TIMERWIDTH-1:0] HoldLast   = TIMERWIDTH'(HOLDCYCLES - 1);
  localparam logic [TIMERWIDTH-1:0] RepeatLast = TIMERWIDTH'(REPEATCYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e                  state_q;
  logic                    sync1_q, sync2_q;
  logic [TIMERWIDTH-1:0]   timer_q;
  logic [COUNTWIDTH-1:0]   count_q;
  logic                    press_q, release_q, repeat_q, longhold_q;

  // Two-flop synchronizer; only sync2_q is used downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.ispressedin;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      count_q    <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      longhold_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sync2_q) begin
            state_q <= StHold;
            press_q <= 1'b1;
            timer_q <= '0;
            count_q <= count_q + 1'b1;
          end
        end
        StHold: begin
          if (!sync2_q) begin
            state_q   <= StIdle;
            release_q <= 1'b1;
          end else if (timer_q == HoldLast) begin
            state_q    <= StRepeat;
            repeat_q   <= 1'b1;
            longhold_q <= 1'b1;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StRepeat: begin
          // Release is tested first so it wins over a coinciding timer expiry.
          if (!sync2_q) begin
            state_q    <= StIdle;
            release_q  <= 1'b1;
            longhold_q <= 1'b0;
            timer_q    <= '0;
          end else if (timer_q == RepeatLast) begin
            repeat_q <= 1'b1;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Clear overrides a same-cycle increment; the press pulse is unaffected.
      if (bus.countclear) begin
        count_q <= '0;
      end
    end
  end

  assign bus.presspulse   = press_q;
  assign bus.releasepulse = release_q;
  assign bus.repeatpulse  = repeat_q;
  assign bus.longhold     = longhold_q;
  assign bus.presscount   = count_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: expected events are queued when stimulus is applied
// and matched against DUT pulses by a negedge monitor.
module tb_key_event_gen;
  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 4;
  localparam int unsigned CW   = 4;

  typedef struct {
    int kind;   // 1 press, 2 release, 3 repeat
    int cycle;
    int count;
    int lh;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [CW-1:0] exp_count = '0;
  ev_t  exp_q[$];

  key_event_gen_if #(.COUNTWIDTH(CW)) bus ();

  key_event_gen #(
    .HOLDCYCLES  (HOLD),
    .REPEATCYCLES(REP),
    .TIMERWIDTH  (24),
    .COUNTWIDTH  (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push(input int kind, input int cycle, input int lh);
    ev_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.count = int'(exp_count);
    e.lh    = lh;
    exp_q.push_back(e);
  endtask

  // Raise the input for 'hold' clocks and queue the press, repeats and release it implies.
  task automatic press_hold(input int hold, input int clr);
    int n, p, l;
    @(negedge clock);
    n = cyc + 1;
    p = n + 2;
    l = n + hold + 2;
    exp_count = (clr != 0) ? '0 : exp_count + 1'b1;
    push(1, p, 0);
    for (int t = p + HOLD; t < l; t += REP) push(3, t, 1);
    push(2, l, 0);
    bus.ispressedin = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      bus.countclear = (clr != 0) && (cyc == p - 1);
    end
    bus.ispressedin = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clock) begin : mon
    int  kind;
    ev_t e;
    if (!reset) begin
      chk("pulse_exclusive",
          int'($countones({bus.presspulse, bus.releasepulse, bus.repeatpulse}) <= 1), 1);
      while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
        e = exp_q.pop_front();
        chk("missed_event_kind", 0, e.kind);
      end
      if (bus.presspulse || bus.releasepulse || bus.repeatpulse) begin
        kind = bus.presspulse ? 1 : (bus.releasepulse ? 2 : 3);
        if (exp_q.size() == 0) begin
          chk("unexpected_event_kind", kind, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cycle);
          chk("presscount", int'(bus.presscount), e.count);
          chk("longhold", int'(bus.longhold), e.lh);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, p, k;
    bus.ispressedin = 1'b0;
    bus.countclear  = 1'b0;
    #1;
    chk("reset_presspulse", int'(bus.presspulse), 0);
    chk("reset_releasepulse", int'(bus.releasepulse), 0);
    chk("reset_repeatpulse", int'(bus.repeatpulse), 0);
    chk("reset_longhold", int'(bus.longhold), 0);
    chk("reset_presscount", int'(bus.presscount), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Short press: no repeat, longhold stays low.
    press_hold(5, 0);
    drain();
    chk("short_press_longhold", int'(bus.longhold), 0);

    // Long hold: five repeats at +8, +12, ..., +24.
    press_hold(26, 0);
    drain();

    // Release coincides with repeat-timer expiry: release wins.
    press_hold(12, 0);
    drain();
    chk("coincide_longhold", int'(bus.longhold), 0);

    @(negedge clock);
    bus.countclear = 1'b1;
    @(negedge clock);
    bus.countclear = 1'b0;
    exp_count = '0;
    chk("countclear_idle", int'(bus.presscount), 0);

    // 17 presses wrap the counter 15 -> 0 -> 1; the 18th press clears it.
    for (int i = 0; i < 17; i++) begin
      press_hold(3, 0);
      repeat (2) @(negedge clock);
    end
    chk("wrap_count", int'(bus.presscount), 1);
    press_hold(3, 1);
    drain();
    chk("clear_on_press_count", int'(bus.presscount), 0);

    // Asynchronous reset in the middle of REPEAT with the key still held.
    @(negedge clock);
    n = cyc + 1;
    p = n + 2;
    exp_count = exp_count + 1'b1;
    push(1, p, 0);
    push(3, p + HOLD, 1);
    bus.ispressedin = 1'b1;
    while (cyc < p + 10) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_presspulse", int'(bus.presspulse), 0);
    chk("async_releasepulse", int'(bus.releasepulse), 0);
    chk("async_repeatpulse", int'(bus.repeatpulse), 0);
    chk("async_longhold", int'(bus.longhold), 0);
    chk("async_presscount", int'(bus.presscount), 0);
    chk("pre_reset_events", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    k = cyc;
    exp_count = 4'd1;
    push(1, k + 3, 0);
    push(2, k + 7, 0);
    while (cyc < k + 4) @(negedge clock);
    bus.ispressedin = 1'b0;
    drain();

    // One-clock input pulse: press then release one cycle later.
    press_hold(1, 0);
    drain();

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
